// File: rtl/idu_issue_queue.sv
// ---------------------------------------------------------------------------
// idu_issue_queue
//   DEPTH-entry FIFO of decoded instruction packets sitting between decode and
//   EX. Decouples decode throughput from EX stalls. Packet contents are opaque.
//
// Ports
//   clk           core clock
//   rst_n         synchronous active-low reset (clears pointers, count, storage)
//   in_valid_i    decode presents a packet
//   in_ready_o    queue has a free slot (from registered count only)
//   in_data_i     decoded packet payload
//   in_addr_i     instruction address of the packet
//   flush_i       discard all queued entries (redirect); drops same-cycle input
//   hold_i        pipeline hold; suppresses out_valid_o, blocks issue
//   out_valid_o   head packet valid for EX
//   out_ready_i   EX accepts the head packet
//   out_data_o    head packet payload
//   out_addr_o    head instruction address
//   count_o       current occupancy
//   almost_full_o occupancy at or above AF_LEVEL
// ---------------------------------------------------------------------------
module idu_issue_queue #(
  parameter int PAYLOAD_W = 128,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 4,
  parameter int AF_LEVEL  = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [PAYLOAD_W-1:0]         in_data_i,
  input  logic [ADDR_W-1:0]            in_addr_i,
  input  logic                         flush_i,
  input  logic                         hold_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [PAYLOAD_W-1:0]         out_data_o,
  output logic [ADDR_W-1:0]            out_addr_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         almost_full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C     = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);

  logic [PAYLOAD_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0]    addr_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic enq_s;
  logic deq_s;

  // Status flags come only from the registered count, so in_ready_o has no
  // combinational dependence on out_ready_i.
  assign in_ready_o    = (count_q < DEPTH_C);
  assign almost_full_o = (count_q >= AF_C);
  assign count_o       = count_q;

  // Hold masks the valid seen by EX, which also blocks dequeue.
  assign out_valid_o = (count_q != CNT_ZERO) & ~hold_i;

  // Head is read straight from storage; it only changes when rd_ptr moves,
  // so it is stable while EX back-pressures.
  assign out_data_o = data_q[rd_ptr_q];
  assign out_addr_o = addr_q[rd_ptr_q];

  assign enq_s = in_valid_i  & in_ready_o  & ~flush_i;
  assign deq_s = out_valid_o & out_ready_i & ~flush_i;

  // Next-state for pointers and occupancy; flush resets the bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
      count_d  = CNT_ZERO;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (enq_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (deq_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({enq_s, deq_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers; reset wins over flush/enq/deq.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Packet storage; cleared on reset only, a flush leaves contents in place.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= {PAYLOAD_W{1'b0}};
        addr_q[i] <= {ADDR_W{1'b0}};
      end
    end else if (enq_s) begin
      data_q[wr_ptr_q] <= in_data_i;
      addr_q[wr_ptr_q] <= in_addr_i;
    end else begin
      data_q[wr_ptr_q] <= data_q[wr_ptr_q];
      addr_q[wr_ptr_q] <= addr_q[wr_ptr_q];
    end
  end

endmodule

// File: tb/tb_idu_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_idu_issue_queue
//   Directed vector table for the queue's corner cases, a short hand-written
//   sequence for reset-over-everything, then randomized traffic checked
//   against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_idu_issue_queue;

  localparam int DEPTH = 4;
  localparam int PW    = 128;
  localparam int AW    = 32;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [PW-1:0] in_data_i;
  logic [AW-1:0] in_addr_i;
  logic          flush_i;
  logic          hold_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [PW-1:0] out_data_o;
  logic [AW-1:0] out_addr_o;
  logic [CW-1:0] count_o;
  logic          almost_full_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  idu_issue_queue #(
    .PAYLOAD_W (PW),
    .ADDR_W    (AW),
    .DEPTH     (DEPTH),
    .AF_LEVEL  (DEPTH - 1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_data_i     (in_data_i),
    .in_addr_i     (in_addr_i),
    .flush_i       (flush_i),
    .hold_i        (hold_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_data_o    (out_data_o),
    .out_addr_o    (out_addr_o),
    .count_o       (count_o),
    .almost_full_o (almost_full_o)
  );

  typedef struct {
    logic          r;
    logic          iv;
    logic          fl;
    logic          hd;
    logic          ordy;
    logic [PW-1:0] d;
    logic [AW-1:0] a;
    int            e_cnt;
    logic          e_ov;
    logic          e_ir;
    logic          e_af;
    logic          chk_d;
    logic [PW-1:0] e_d;
    logic [AW-1:0] e_a;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Directed packets 0x11.. map to addresses 0x80000000, +4, ...
  function automatic logic [AW-1:0] addr_of(input logic [7:0] d);
    return 32'h8000_0000 + {22'd0, d, 2'b00} - 32'h44;
  endfunction

  function automatic void add(input logic r, input logic iv, input logic [7:0] d,
                              input logic fl, input logic hd, input logic ordy,
                              input int cnt, input logic ov, input logic [7:0] ed,
                              input logic chk_d);
    vec_t v;
    v.r     = r;
    v.iv    = iv;
    v.fl    = fl;
    v.hd    = hd;
    v.ordy  = ordy;
    v.d     = {120'd0, d};
    v.a     = addr_of(d);
    v.e_cnt = cnt;
    v.e_ov  = ov;
    v.e_ir  = (cnt < DEPTH);
    v.e_af  = (cnt >= DEPTH - 1);
    v.chk_d = chk_d;
    v.e_d   = {120'd0, ed};
    v.e_a   = (ed == 8'h00) ? 32'h0 : addr_of(ed);
    tbl.push_back(v);
  endfunction

  task automatic set_in(input logic r, input logic iv, input logic [PW-1:0] d,
                        input logic [AW-1:0] a, input logic fl, input logic hd,
                        input logic ordy);
    rst_n       = r;
    in_valid_i  = iv;
    in_data_i   = d;
    in_addr_i   = a;
    flush_i     = fl;
    hold_i      = hd;
    out_ready_i = ordy;
  endtask

  // Outputs are sampled 1 time unit after the edge with the same inputs held.
  task automatic check_status(input string tag, input int cnt, input logic ov);
    chk({tag, ".count"},  {125'd0, count_o},       PW'(cnt));
    chk({tag, ".ovalid"}, {127'd0, out_valid_o},   {127'd0, ov});
    chk({tag, ".iready"}, {127'd0, in_ready_o},    {127'd0, (cnt < DEPTH)});
    chk({tag, ".afull"},  {127'd0, almost_full_o}, {127'd0, (cnt >= DEPTH - 1)});
  endtask

  logic [PW+AW-1:0] mq[$];

  initial begin
    set_in(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // ---------------- directed vector table ----------------
    // r iv  d     fl hd or  cnt ov  ed    chk
    add(0, 1, 8'h99, 0, 0, 0,  0, 0, 8'h00, 1);
    add(0, 1, 8'h99, 0, 0, 0,  0, 0, 8'h00, 1);
    add(1, 1, 8'h11, 0, 0, 0,  1, 1, 8'h11, 1);
    add(1, 1, 8'h12, 0, 0, 0,  2, 1, 8'h11, 1);
    add(1, 1, 8'h13, 0, 0, 0,  3, 1, 8'h11, 1);
    add(1, 1, 8'h14, 0, 0, 0,  4, 1, 8'h11, 1);
    add(1, 1, 8'h15, 0, 0, 0,  4, 1, 8'h11, 1);   // full: offer dropped
    add(1, 0, 8'h00, 0, 0, 1,  3, 1, 8'h12, 1);
    add(1, 0, 8'h00, 0, 0, 1,  2, 1, 8'h13, 1);
    add(1, 0, 8'h00, 0, 0, 1,  1, 1, 8'h14, 1);
    add(1, 0, 8'h00, 0, 0, 1,  0, 0, 8'h00, 0);
    add(1, 0, 8'h00, 0, 0, 1,  0, 0, 8'h00, 0);   // empty ignores ready
    add(1, 1, 8'h21, 0, 0, 0,  1, 1, 8'h21, 1);
    add(1, 1, 8'h22, 0, 0, 0,  2, 1, 8'h21, 1);
    add(1, 1, 8'h23, 0, 0, 0,  3, 1, 8'h21, 1);
    add(1, 1, 8'h24, 0, 0, 0,  4, 1, 8'h21, 1);
    add(1, 1, 8'h25, 0, 0, 1,  3, 1, 8'h22, 1);   // full + deq: deq only
    add(1, 1, 8'h25, 0, 0, 1,  3, 1, 8'h23, 1);   // now enq + deq
    add(1, 0, 8'h00, 0, 0, 1,  2, 1, 8'h24, 1);
    add(1, 0, 8'h00, 0, 0, 1,  1, 1, 8'h25, 1);
    add(1, 0, 8'h00, 0, 0, 1,  0, 0, 8'h00, 0);
    add(1, 1, 8'h31, 0, 0, 0,  1, 1, 8'h31, 1);
    add(1, 1, 8'h32, 0, 0, 0,  2, 1, 8'h31, 1);
    for (int i = 0; i < 3; i++) add(1, 0, 8'h00, 0, 1, 1, 2, 0, 8'h00, 0);
    add(1, 0, 8'h00, 0, 0, 0,  2, 1, 8'h31, 1);   // hold released
    add(1, 1, 8'h33, 0, 0, 0,  3, 1, 8'h31, 1);
    add(1, 1, 8'h34, 1, 0, 0,  0, 0, 8'h00, 0);   // flush drops 0x34
    add(1, 1, 8'h55, 0, 0, 0,  1, 1, 8'h55, 1);
    add(1, 1, 8'h56, 0, 0, 0,  2, 1, 8'h55, 1);
    for (int i = 0; i < 10; i++)
      add(1, 1, 8'(8'h60 + i), 0, 0, 1, 2, 1, (i == 0) ? 8'h56 : 8'(8'h5F + i), 1);

    foreach (tbl[k]) begin
      set_in(tbl[k].r, tbl[k].iv, tbl[k].d, tbl[k].a, tbl[k].fl, tbl[k].hd, tbl[k].ordy);
      @(posedge clk);
      #1;
      check_status($sformatf("vec%0d", k), tbl[k].e_cnt, tbl[k].e_ov);
      if (tbl[k].chk_d) begin
        chk($sformatf("vec%0d.data", k), out_data_o, tbl[k].e_d);
        chk($sformatf("vec%0d.addr", k), {96'd0, out_addr_o}, {96'd0, tbl[k].e_a});
      end
    end

    // ---------------- hand sequence: stall stability, then reset over all ----
    // Queue now holds 0x68, 0x69.
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_status("stall", 2, 1'b1);
      chk("stall.data", out_data_o, {120'd0, 8'h68});
      chk("stall.addr", {96'd0, out_addr_o}, {96'd0, addr_of(8'h68)});
    end
    set_in(1'b0, 1'b1, {120'd0, 8'h77}, addr_of(8'h77), 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check_status("midrst", 0, 1'b0);
    chk("midrst.data", out_data_o, '0);
    chk("midrst.addr", {96'd0, out_addr_o}, '0);

    // ---------------- randomized traffic vs reference queue ----------------
    mq.delete();
    for (int c = 0; c < 3000; c++) begin
      logic          r, iv, fl, hd, ordy, m_ov, m_enq, m_deq;
      logic [PW-1:0] d;
      logic [AW-1:0] a;
      r    = (c == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
      iv   = ($urandom_range(0, 9) < 6);
      fl   = ($urandom_range(0, 49) == 0);
      hd   = ($urandom_range(0, 6) == 0);
      ordy = ($urandom_range(0, 1) == 1);
      d    = {$urandom, $urandom, $urandom, $urandom};
      a    = $urandom;
      set_in(r, iv, d, a, fl, hd, ordy);
      m_ov  = (mq.size() != 0) && !hd;
      m_enq = iv && (mq.size() < DEPTH) && !fl;
      m_deq = m_ov && ordy && !fl;
      @(posedge clk);
      if (!r || fl) begin
        mq.delete();
      end else begin
        if (m_deq) void'(mq.pop_front());
        if (m_enq) mq.push_back({d, a});
      end
      #1;
      check_status($sformatf("rnd%0d", c), mq.size(), (mq.size() != 0) && !hd);
      if ((mq.size() != 0) && !hd) begin
        chk($sformatf("rnd%0d.data", c), out_data_o, mq[0][PW+AW-1:AW]);
        chk($sformatf("rnd%0d.addr", c), {96'd0, out_addr_o}, {96'd0, mq[0][AW-1:0]});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
